// File: rtl/in_chn_router_fsm.sv
`default_nettype none
// ============================================================================
// Module   : in_chn_router_fsm
// Purpose  : Router input-channel FSM that parses header/payload/parity frames
//            and steers bytes to one of NUM_PORTS FIFOs with classified errors.
//            Optional error event counter enabled by macro IN_CHN_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module in_chn_router_fsm #(
  parameter int data_size       = 8,
  parameter int pkt_length_bits = 5,
  parameter int pkt_addr_bits   = data_size - pkt_length_bits,
  parameter int NUM_PORTS       = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_ch_en,
  input  logic [data_size-1:0]   i_data_in,
  input  logic                   i_clr_errors,
  input  logic [NUM_PORTS-1:0]   i_fifo_full,
  output logic                   o_busy,
  output logic                   o_error,
  output logic [4:0]             o_err_code,
  output logic [data_size-1:0]   o_data_out,
  output logic [NUM_PORTS-1:0]   o_pkt_to_fifo_en,
  output logic                   o_pkt_done,
  output logic                   o_pkt_ok
`ifdef IN_CHN_ERR_CNT_EN
  ,
  output logic [7:0]             o_err_cnt
`endif
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_payload = 3'd1;
  localparam logic [2:0] c_st_parity  = 3'd2;
  localparam logic [2:0] c_st_gap     = 3'd3;
  localparam logic [2:0] c_st_drop    = 3'd4;

  // Extra bit so NUM_PORTS == 2**pkt_addr_bits is representable.
  localparam logic [pkt_addr_bits:0] c_num_ports = (pkt_addr_bits + 1)'(NUM_PORTS);

  logic [2:0]                 r_state;
  logic [pkt_addr_bits-1:0]   r_addr;
  logic [pkt_length_bits-1:0] r_cnt;
  logic [data_size-1:0]       r_acc;
  logic [data_size-1:0]       r_data_out;
  logic [NUM_PORTS-1:0]       r_wr_en;
  logic                       r_done;
  logic                       r_ok;
  logic [4:0]                 r_err;

  logic [2:0]                 w_state_nxt;
  logic [pkt_addr_bits-1:0]   w_addr_nxt;
  logic [pkt_length_bits-1:0] w_cnt_nxt;
  logic [data_size-1:0]       w_acc_nxt;
  logic [data_size-1:0]       w_wr_data;
  logic [NUM_PORTS-1:0]       w_wr_en;
  logic                       w_done;
  logic                       w_ok;
  logic [4:0]                 w_err_set;

  logic [pkt_addr_bits-1:0]   w_hdr_addr;
  logic [pkt_length_bits-1:0] w_hdr_len;
  logic [NUM_PORTS-1:0]       w_hdr_sel;
  logic [NUM_PORTS-1:0]       w_pay_sel;
  logic                       w_hdr_full;
  logic                       w_pay_full;

  assign w_hdr_addr = i_data_in[pkt_addr_bits-1:0];
  assign w_hdr_len  = i_data_in[data_size-1:pkt_addr_bits];
  assign w_hdr_sel  = NUM_PORTS'(1) << w_hdr_addr;
  assign w_pay_sel  = NUM_PORTS'(1) << r_addr;
  assign w_hdr_full = |(i_fifo_full & w_hdr_sel);
  assign w_pay_full = |(i_fifo_full & w_pay_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_wr_data   = '0;
    w_wr_en     = '0;
    w_done      = 1'b0;
    w_ok        = 1'b0;
    w_err_set   = '0;
    case (r_state)
      c_st_idle: begin
        if (i_ch_en) begin
          if ({1'b0, w_hdr_addr} >= c_num_ports) begin
            w_err_set[0] = 1'b1;
            w_state_nxt  = c_st_drop;
          end else if (w_hdr_len == '0) begin
            w_err_set[1] = 1'b1;
            w_state_nxt  = c_st_drop;
          end else if (w_hdr_full) begin
            w_err_set[4] = 1'b1;
            w_state_nxt  = c_st_drop;
          end else begin
            w_wr_en     = w_hdr_sel;
            w_wr_data   = i_data_in;
            w_addr_nxt  = w_hdr_addr;
            w_cnt_nxt   = w_hdr_len;
            w_acc_nxt   = i_data_in;
            w_state_nxt = c_st_payload;
          end
        end
      end
      c_st_payload: begin
        // A dropped frame valid is checked before FIFO space: it is not a data cycle.
        if (!i_ch_en) begin
          w_err_set[3] = 1'b1;
          w_done       = 1'b1;
          w_state_nxt  = c_st_idle;
        end else if (w_pay_full) begin
          w_err_set[4] = 1'b1;
          w_done       = 1'b1;
          w_state_nxt  = c_st_drop;
        end else begin
          w_wr_en   = w_pay_sel;
          w_wr_data = i_data_in;
          w_acc_nxt = r_acc ^ i_data_in;
          w_cnt_nxt = r_cnt - pkt_length_bits'(1);
          if (r_cnt == pkt_length_bits'(1)) w_state_nxt = c_st_parity;
        end
      end
      c_st_parity: begin
        w_done = 1'b1;
        if (!i_ch_en) begin
          w_err_set[3] = 1'b1;
          w_state_nxt  = c_st_idle;
        end else begin
          w_ok         = (i_data_in == r_acc);
          w_err_set[2] = (i_data_in != r_acc);
          w_state_nxt  = c_st_gap;
        end
      end
      c_st_gap: begin
        if (i_ch_en) begin
          w_err_set[3] = 1'b1;
          w_state_nxt  = c_st_drop;
        end else begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_drop: begin
        if (!i_ch_en) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= c_st_idle;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_data_out <= '0;
      r_wr_en    <= '0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_data_out <= w_wr_data;
      r_wr_en    <= w_wr_en;
      r_done     <= w_done;
      r_ok       <= w_ok;
      // New errors are OR-ed after the clear so they survive it.
      r_err      <= (i_clr_errors ? 5'b0 : r_err) | w_err_set;
    end
  end

`ifdef IN_CHN_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err_cnt <= '0;
    end else if (i_clr_errors) begin
      r_err_cnt <= (|w_err_set) ? 8'd1 : 8'd0;
    end else if ((|w_err_set) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

  assign o_busy           = (r_state != c_st_idle);
  assign o_error          = |r_err;
  assign o_err_code       = r_err;
  assign o_data_out       = r_data_out;
  assign o_pkt_to_fifo_en = r_wr_en;
  assign o_pkt_done       = r_done;
  assign o_pkt_ok         = r_ok;

endmodule
`default_nettype wire
